// File: rtl/spi_slave_pkg.sv
// Shared opcodes, widths and sequencer state encoding for the SPI slave
// command controller.
package spi_slave_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  localparam logic [7:0] CMD_WR    = 8'h01;
  localparam logic [7:0] CMD_RD    = 8'h02;
  localparam logic [7:0] IDLE_BYTE = 8'h00;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    WR_HI,
    WR_LO,
    RD_REQ,
    RD_WAIT,
    RD_HI,
    RD_LO,
    DISCARD
  } state_t;

endpackage

// File: rtl/spi_slave_cmd_ctrl.sv
// Command decoder and RAM sequencer: parses opcode/address/data bytes from the
// SPI shifter, drives single-cycle RAM strobes and streams read words back.
module spi_slave_cmd_ctrl
  import spi_slave_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic              tx_take,
  output logic [7:0]        tx_byte,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [7:0]        err_cnt,
  output state_t            state_dbg
);

  // Byte-side handshake: rx_valid and tx_take are single-cycle pulses with no
  // back-pressure; a pulse is consumed only in a state that expects it and
  // only while cs_n is low, otherwise it is dropped.

  state_t              state, state_n;
  logic                wr_mode, wr_mode_n;
  logic [ADDR_W-1:0]   ptr, ptr_n;
  logic [7:0]          hi_byte, hi_byte_n;
  logic [7:0]          shadow_lo, shadow_lo_n;
  logic [7:0]          tx_byte_n;
  logic                ram_we_n, ram_re_n;
  logic [ADDR_W-1:0]   ram_waddr_n, ram_raddr_n;
  logic [DATA_W-1:0]   ram_wdata_n;
  logic [7:0]          err_cnt_n;

  assign state_dbg = state;

  always_comb begin
    state_n     = state;
    wr_mode_n   = wr_mode;
    ptr_n       = ptr;
    hi_byte_n   = hi_byte;
    shadow_lo_n = shadow_lo;
    tx_byte_n   = tx_byte;
    ram_we_n    = 1'b0;
    ram_waddr_n = ram_waddr;
    ram_wdata_n = ram_wdata;
    ram_re_n    = 1'b0;
    ram_raddr_n = ram_raddr;
    err_cnt_n   = err_cnt;

    if (cs_n) begin
      // Frame end beats any byte event in the same cycle.
      state_n   = IDLE;
      tx_byte_n = IDLE_BYTE;
    end else begin
      unique case (state)
        IDLE: begin
          if (rx_valid) begin
            if (rx_byte == CMD_WR) begin
              state_n   = ADDR;
              wr_mode_n = 1'b1;
            end else if (rx_byte == CMD_RD) begin
              state_n   = ADDR;
              wr_mode_n = 1'b0;
            end else begin
              state_n   = DISCARD;
              err_cnt_n = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
            end
          end
        end
        ADDR: begin
          if (rx_valid) begin
            ptr_n   = rx_byte;
            state_n = wr_mode ? WR_HI : RD_REQ;
          end
        end
        WR_HI: begin
          if (rx_valid) begin
            hi_byte_n = rx_byte;
            state_n   = WR_LO;
          end
        end
        WR_LO: begin
          if (rx_valid) begin
            ram_we_n    = 1'b1;
            ram_waddr_n = ptr;
            ram_wdata_n = {hi_byte, rx_byte};
            ptr_n       = ptr + 8'd1;
            state_n     = WR_HI;
          end
        end
        RD_REQ: state_n = RD_WAIT;
        RD_WAIT: begin
          shadow_lo_n = ram_rdata[7:0];
          tx_byte_n   = ram_rdata[15:8];
          state_n     = RD_HI;
        end
        RD_HI: begin
          if (tx_take) begin
            tx_byte_n = shadow_lo;
            state_n   = RD_LO;
          end
        end
        RD_LO: begin
          if (tx_take) begin
            ptr_n   = ptr + 8'd1;
            state_n = RD_REQ;
          end
        end
        DISCARD: state_n = DISCARD;
        default: state_n = IDLE;
      endcase
    end

    // The read strobe is registered on entry so it is high while in RD_REQ,
    // one cycle after the address byte or the low-byte take.
    if (state_n == RD_REQ) begin
      ram_re_n    = 1'b1;
      ram_raddr_n = ptr_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_mode   <= 1'b0;
      ptr       <= '0;
      hi_byte   <= 8'h00;
      shadow_lo <= 8'h00;
      tx_byte   <= IDLE_BYTE;
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      ram_re    <= 1'b0;
      ram_raddr <= '0;
      err_cnt   <= 8'h00;
    end else begin
      state     <= state_n;
      wr_mode   <= wr_mode_n;
      ptr       <= ptr_n;
      hi_byte   <= hi_byte_n;
      shadow_lo <= shadow_lo_n;
      tx_byte   <= tx_byte_n;
      ram_we    <= ram_we_n;
      ram_waddr <= ram_waddr_n;
      ram_wdata <= ram_wdata_n;
      ram_re    <= ram_re_n;
      ram_raddr <= ram_raddr_n;
      err_cnt   <= err_cnt_n;
    end
  end

endmodule

// File: tb/tb_spi_slave_cmd_ctrl.sv
// Directed-plus-random bench for spi_slave_cmd_ctrl with a behavioural RAM
// image and an expected-write queue derived from the frames sent.
module tb_spi_slave_cmd_ctrl;
  import spi_slave_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cs_n;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        tx_take;
  logic [7:0]  tx_byte;
  logic        ram_we;
  logic [7:0]  ram_waddr;
  logic [15:0] ram_wdata;
  logic        ram_re;
  logic [7:0]  ram_raddr;
  logic [15:0] ram_rdata;
  logic [7:0]  err_cnt;
  state_t      state_dbg;

  spi_slave_cmd_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs_n      (cs_n),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .tx_take   (tx_take),
    .tx_byte   (tx_byte),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_re    (ram_re),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .err_cnt   (err_cnt),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM environment (the thing the DUT talks to)
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_raddr];
  end

  // reference model state
  logic [15:0] mem_ref [256];
  logic [23:0] exp_q [$];
  logic [23:0] got_w [$];
  logic [15:0] burst [$];
  int          err_ref;
  int          re_cnt;
  int          both_cnt;
  int          checks;
  int          errors;

  always @(negedge clk) begin
    if (ram_we) got_w.push_back({ram_waddr, ram_wdata});
    if (ram_re) re_cnt++;
    if (ram_we && ram_re) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: each starts and ends on a falling edge
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic take();
    tx_take = 1'b1;
    @(negedge clk);
    tx_take = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic start_frame();
    cs_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic end_frame();
    cs_n = 1'b1;
    @(negedge clk);
    chk("end_tx_idle", 32'(tx_byte), 32'h0);
    chk("end_state_idle", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
  endtask

  task automatic cmp_writes();
    int n;
    chk("wr_count", 32'(got_w.size()), 32'(exp_q.size()));
    n = (got_w.size() < exp_q.size()) ? got_w.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk("wr_strobe", 32'(got_w[i]), 32'(exp_q[i]));
    got_w.delete();
    exp_q.delete();
  endtask

  task automatic wr_frame(input logic [7:0] addr);
    logic [7:0] a;
    a = addr;
    start_frame();
    send_byte(CMD_WR);
    gap();
    send_byte(addr);
    foreach (burst[i]) begin
      gap();
      send_byte(burst[i][15:8]);
      gap();
      send_byte(burst[i][7:0]);
      chk("wr_we", 32'(ram_we), 32'h1);
      chk("wr_addr", 32'(ram_waddr), 32'(a));
      chk("wr_data", 32'(ram_wdata), 32'(burst[i]));
      exp_q.push_back({a, burst[i]});
      mem_ref[a] = burst[i];
      a = a + 8'd1;
    end
    end_frame();
    cmp_writes();
  endtask

  task automatic rd_frame(input logic [7:0] addr, input int nwords);
    logic [7:0]  a;
    logic [15:0] w;
    a = addr;
    start_frame();
    send_byte(CMD_RD);
    gap();
    send_byte(addr);
    for (int k = 0; k < nwords; k++) begin
      w = mem_ref[a];
      chk("rd_re", 32'(ram_re), 32'h1);
      chk("rd_raddr", 32'(ram_raddr), 32'(a));
      repeat (2 + $urandom_range(0, 2)) @(negedge clk);
      chk("rd_hi", 32'(tx_byte), 32'(w[15:8]));
      take();
      chk("rd_lo", 32'(tx_byte), 32'(w[7:0]));
      gap();
      take();
      a = a + 8'd1;
    end
    end_frame();
  endtask

  initial begin
    logic [15:0] v;
    logic [7:0]  ra;
    int          we_before;
    int          re_before;
    checks   = 0;
    errors   = 0;
    err_ref  = 0;
    re_cnt   = 0;
    both_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      mem[i]     = v;
      mem_ref[i] = v;
    end
    rst_n    = 1'b0;
    cs_n     = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    tx_take  = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_tx", 32'(tx_byte), 32'h0);
    chk("rst_we", 32'(ram_we), 32'h0);
    chk("rst_re", 32'(ram_re), 32'h0);
    chk("rst_waddr", 32'(ram_waddr), 32'h0);
    chk("rst_raddr", 32'(ram_raddr), 32'h0);
    chk("rst_wdata", 32'(ram_wdata), 32'h0);
    chk("rst_err", 32'(err_cnt), 32'h0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // directed write burst
    burst = '{16'hABCD, 16'h1234};
    wr_frame(8'h10);

    // directed read burst
    mem[8'h20] = 16'hBEEF; mem_ref[8'h20] = 16'hBEEF;
    mem[8'h21] = 16'hCAFE; mem_ref[8'h21] = 16'hCAFE;
    rd_frame(8'h20, 2);

    // address wrap on write and read
    burst = '{16'h0001, 16'h0002};
    wr_frame(8'hFF);
    rd_frame(8'hFF, 2);

    // random write bursts followed by read-back
    for (int t = 0; t < 6; t++) begin
      ra = 8'($urandom);
      burst.delete();
      for (int k = 0; k < $urandom_range(1, 4); k++) burst.push_back(16'($urandom));
      wr_frame(ra);
      rd_frame(ra, burst.size());
    end
    for (int t = 0; t < 4; t++) rd_frame(8'($urandom), $urandom_range(1, 3));

    // abort mid-word, then a clean frame
    start_frame();
    send_byte(CMD_WR);
    send_byte(8'h05);
    send_byte(8'hAA);
    end_frame();
    cmp_writes();
    burst = '{16'h1122};
    wr_frame(8'h06);

    // low byte coincident with cs_n rising is ignored
    start_frame();
    send_byte(CMD_WR);
    send_byte(8'h30);
    send_byte(8'h11);
    cs_n     = 1'b1;
    rx_valid = 1'b1;
    rx_byte  = 8'h22;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    chk("race_no_we", 32'(got_w.size()), 32'h0);
    chk("race_state", 32'(state_dbg), 32'(IDLE));
    cmp_writes();

    // bad opcodes: no strobes, saturating error count
    we_before = got_w.size();
    re_before = re_cnt;
    for (int f = 0; f < 300; f++) begin
      start_frame();
      send_byte(8'h7E);
      send_byte(8'($urandom));
      err_ref = (err_ref < 255) ? err_ref + 1 : 255;
      end_frame();
      chk("err_cnt", 32'(err_cnt), 32'(err_ref));
    end
    chk("bad_no_we", 32'(got_w.size()), 32'(we_before));
    chk("bad_no_re", 32'(re_cnt), 32'(re_before));
    chk("err_sat", 32'(err_cnt), 32'hFF);

    // asynchronous reset while waiting on read data
    mem[8'h40] = 16'h5A5A; mem_ref[8'h40] = 16'h5A5A;
    start_frame();
    send_byte(CMD_RD);
    send_byte(8'h40);
    @(negedge clk);
    chk("pre_rst_state", 32'(state_dbg), 32'(RD_WAIT));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx", 32'(tx_byte), 32'h0);
    chk("arst_we", 32'(ram_we), 32'h0);
    chk("arst_re", 32'(ram_re), 32'h0);
    chk("arst_waddr", 32'(ram_waddr), 32'h0);
    chk("arst_raddr", 32'(ram_raddr), 32'h0);
    chk("arst_wdata", 32'(ram_wdata), 32'h0);
    chk("arst_err", 32'(err_cnt), 32'h0);
    chk("arst_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    cs_n  = 1'b1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    got_w.delete();

    // block works again after reset
    burst = '{16'($urandom), 16'($urandom)};
    wr_frame(8'h80);
    rd_frame(8'h80, 2);

    chk("we_re_overlap", 32'(both_cnt), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_cmd_ctrl.md
# spi_slave_cmd_ctrl

Command decoder and RAM sequencer between the SPI slave byte shifter and the 256 x 16 slave RAM. It parses framed byte streams (command, address, data), issues single-cycle write and read strobes to the RAM, and feeds 16-bit read data back to the shifter's transmit side as two bytes. Bursts auto-increment the address within a frame.

## Interface
- ADDR_W, 8, RAM address width (256 words)
- DATA_W, 16, RAM word width; fixed at 2 bytes
- CMD_WR, 8'h01, write-burst opcode
- CMD_RD, 8'h02, read-burst opcode
- clk  in  1  system clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- cs_n  in  1  chip select, already synchronised to clk; high = frame idle
- rx_valid  in  1  one-cycle pulse: rx_byte holds a completed MOSI byte
- rx_byte  in  8  received byte
- tx_take  in  1  one-cycle pulse: shifter has latched tx_byte for the next MISO byte
- tx_byte  out  8  next byte to transmit; registered
- ram_we  out  1  write strobe, one cycle
- ram_waddr  out  8  write address
- ram_wdata  out  16  write data
- ram_re  out  1  read strobe, one cycle
- ram_raddr  out  8  read address
- ram_rdata  in  16  RAM read data, valid the cycle after ram_re
- err_cnt  out  8  saturating count of unknown opcodes

## Operation
- States: IDLE, ADDR, WR_HI, WR_LO, RD_REQ, RD_WAIT, RD_HI, RD_LO, DISCARD.
- IDLE: first rx_valid with cs_n low is the opcode.
  - CMD_WR goes to ADDR (write mode).
  - CMD_RD goes to ADDR (read mode).
  - Any other opcode goes to DISCARD and increments err_cnt, which saturates at 8'hFF.
- ADDR: rx_valid latches the pointer.
  - Write mode goes to WR_HI.
  - Read mode goes to RD_REQ.
- WR_HI: rx_valid stores the high byte, then goes to WR_LO.
- WR_LO: rx_valid completes the word.
  - Next cycle: ram_we=1, ram_waddr=ptr, ram_wdata={hi,lo}.
  - ptr increments and wraps 8'hFF to 8'h00. State returns to WR_HI.
- RD_REQ: ram_re=1 and ram_raddr=ptr for one cycle, then goes to RD_WAIT.
- RD_WAIT: captures ram_rdata into the shadow word and sets tx_byte=word[15:8]. Goes to RD_HI.
- RD_HI: tx_take sets tx_byte=word[7:0]. Goes to RD_LO.
- RD_LO: tx_take increments ptr (with wrap) and goes to RD_REQ, which prefetches the next word. Received MOSI bytes are ignored in all read states.
- DISCARD: ignores rx_valid until cs_n rises.
- cs_n high in any state: the next cycle returns to IDLE and tx_byte=8'h00. A partially received write word is dropped and ram_we is not issued. A write strobe already scheduled in the same cycle still completes.
- tx_byte is 8'h00 in IDLE, ADDR, the write states and DISCARD.
- Simultaneous events:
  - rx_valid and cs_n rise in the same cycle: cs_n wins and the byte is ignored.
  - tx_take during RD_REQ/RD_WAIT: the shifter has underrun. tx_byte stays at its old value and no error is raised. The master must allow the 3-cycle prefetch, which is guaranteed when the SCK period is at least 2 clk.

## Timing
- Reset values: tx_byte=8'h00, ram_we=0, ram_re=0, ram_waddr=0, ram_raddr=0, ram_wdata=0, err_cnt=0, state=IDLE, ptr=0.
- Write latency: ram_we is asserted 1 cycle after the rx_valid of the low byte.
- Read latency:
  - ram_re is asserted 1 cycle after the address rx_valid (or after the low-byte tx_take).
  - tx_byte shows the high byte 2 cycles after ram_re was issued.
- ram_we and ram_re are never high together.
- All outputs are registered.
- Reset mid-frame: all outputs clear immediately (asynchronous reset). After release the block waits in IDLE. A frame already in progress when reset releases is treated from its next byte as an opcode; masters must reassert cs_n after reset.

## Structure
- Package spi_slave_pkg holds:
  - the CMD_WR and CMD_RD opcode constants;
  - the state enum type;
  - the IDLE filler byte 8'h00.
- No sub-module. The address pointer with wrap and the saturating err_cnt stay inline in a single FSM plus datapath.

## Test plan
- Write burst:
  - Stimulus: frame 01,10,AB,CD,12,34, then cs_n rises.
  - Response: ram_we at addr 8'h10 with data 16'hABCD, then at addr 8'h11 with data 16'h1234. Exactly 2 strobes.
- Read burst:
  - Preload: mem[8'h20]=16'hBEEF, mem[8'h21]=16'hCAFE.
  - Stimulus: frame 02,20, followed by 4 tx_take pulses.
  - Response: tx_byte sequence BE,EF,CA,FE.
- Wrap:
  - Stimulus: write frame to addr FF with two words, 0001 and 0002.
  - Response: writes land at FF then at 00.
- Bad opcode:
  - Stimulus: frames 7E,.. repeated 300 times.
  - Response: no RAM strobes; err_cnt saturates at 8'hFF.
- Abort:
  - Stimulus: 01,05,AA, then cs_n rises.
  - Response: no ram_we; the next frame 01,06,11,22 writes 16'h1122 to addr 8'h06.
- Reset:
  - Stimulus: assert rst_n low during RD_WAIT.
  - Response: all outputs return to reset values in the same cycle, and state is IDLE.
